// File: rtl/alu_ctrl_mdu_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
//   Shared constants and types for the ALU control decoder with its iterative
//   multiplier:
//     - ALUControl encodings driven to the execute-stage ALU
//     - ALUOp codes produced by the main decoder
//     - R-type Funct field codes
//     - FSM state enum for the multiply sequencer
//     - decode() helper returning {illegal_funct, ALUControl}
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

   // ALUControl encodings
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b100;
   localparam logic [2:0] ALU_MUL = 3'b101;
   localparam logic [2:0] ALU_SLT = 3'b110;

   // ALUOp codes from the main decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;  // loads/stores
   localparam logic [1:0] ALUOP_SUB   = 2'b01;  // branches
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // look at Funct
   localparam logic [1:0] ALUOP_ADDI  = 2'b11;  // immediate add

   // R-type Funct codes
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;
   localparam logic [5:0] FUNCT_MUL = 6'b011100;

   // Multiply sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Returns {illegal_funct, ALUControl}. Unknown R-type functs fall back to
   // ADD so the ALU never sees an undefined control word.
   function automatic logic [3:0] decode(input logic [1:0] aluop,
                                         input logic [5:0] funct);
      logic [3:0] r;
      r = {1'b0, ALU_ADD};
      case (aluop)
         ALUOP_ADD:  r = {1'b0, ALU_ADD};
         ALUOP_SUB:  r = {1'b0, ALU_SUB};
         ALUOP_ADDI: r = {1'b0, ALU_ADD};
         default: begin
            case (funct)
               FUNCT_ADD: r = {1'b0, ALU_ADD};
               FUNCT_SUB: r = {1'b0, ALU_SUB};
               FUNCT_AND: r = {1'b0, ALU_AND};
               FUNCT_OR:  r = {1'b0, ALU_OR};
               FUNCT_SLT: r = {1'b0, ALU_SLT};
               FUNCT_MUL: r = {1'b0, ALU_MUL};
               default:   r = {1'b1, ALU_ADD};
            endcase
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_ctrl_mdu_if.sv
// -----------------------------------------------------------------------------
// alu_ctrl_mdu_if
//   Bus between the main decoder / pipeline control (master) and the ALU
//   control + multiply unit (slave).
//
//   Handshake: the master presents an instruction on ALUOp/Funct/a/b with
//   valid high. The slave answers with stall; while stall is high the master
//   must hold valid and the instruction unchanged. The instruction retires in
//   the first cycle valid is high and stall is low. For MUL that cycle is the
//   one in which mul_done pulses and mul_result carries the product. flush
//   aborts an in-flight MUL and suppresses a start in the same cycle.
//
//   master: valid, flush, ALUOp, Funct, a, b  ->
//           <- ALUControl, illegal_funct, stall, mul_done, mul_result
// -----------------------------------------------------------------------------
interface alu_ctrl_mdu_if #(parameter int WIDTH = 32);
   logic             valid;
   logic             flush;
   logic [1:0]       ALUOp;
   logic [5:0]       Funct;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       ALUControl;
   logic             illegal_funct;
   logic             stall;
   logic             mul_done;
   logic [WIDTH-1:0] mul_result;

   modport master (
      output valid, flush, ALUOp, Funct, a, b,
      input  ALUControl, illegal_funct, stall, mul_done, mul_result
   );

   modport slave (
      input  valid, flush, ALUOp, Funct, a, b,
      output ALUControl, illegal_funct, stall, mul_done, mul_result
   );
endinterface

// File: rtl/alu_ctrl_mdu_mul_iter.sv
// -----------------------------------------------------------------------------
// mul_iter
//   Shift-add multiplier datapath, one multiplier bit per step.
//   Ports:
//     clk          rising-edge clock
//     clear        synchronous clear of every register (highest priority)
//     start        load multiplicand<-a, multiplier<-b, acc<-0, count<-0
//     step         consume one multiplier bit
//     a, b         operands
//     acc          running product, low WIDTH bits (held when idle)
//     last         this step is the final one (count == WIDTH-1)
//     mplier_zero  multiplier after this step would be zero
// -----------------------------------------------------------------------------
module mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             start,
   input  logic             step,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] acc,
   output logic             last,
   output logic             mplier_zero
);
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [CW-1:0]    count;

   always_ff @(posedge clk) begin
      if (clear) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
      end else if (start) begin
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
         count  <= '0;
      end else if (step) begin
         // Only the low WIDTH bits of the product are kept, so the add wraps.
         if (mplier[0]) acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + CW'(1);
      end
   end

   assign last        = (count == CW'(WIDTH - 1));
   // Bit 0 is being consumed this step; what remains is bits [WIDTH-1:1].
   assign mplier_zero = (mplier[WIDTH-1:1] == '0);

endmodule

// File: rtl/alu_ctrl_mdu.sv
// -----------------------------------------------------------------------------
// alu_ctrl_mdu
//   ALU control decoder plus a sequencer for the iterative multiplier.
//   Decode of ALUOp/Funct into ALUControl and illegal_funct is purely
//   combinational. A MUL presented with valid starts the multiplier and
//   holds stall until the product is ready; mul_done pulses for one cycle
//   with mul_result valid, and stall drops that cycle so the MUL retires.
//   Ports:
//     clk, reset   clock and synchronous active-high reset
//     bus          alu_ctrl_mdu_if slave modport (see interface header)
//     state_dbg    current sequencer state
//   Parameters:
//     WIDTH        operand/result width (>= 4)
//     EARLY_EXIT   1 = finish as soon as the remaining multiplier bits are 0
// -----------------------------------------------------------------------------
module alu_ctrl_mdu
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int EARLY_EXIT = 0
) (
   input  logic           clk,
   input  logic           reset,
   alu_ctrl_mdu_if.slave  bus,
   output state_t         state_dbg
);

   state_t           state;
   logic             done_q;
   logic [2:0]       ctrl;
   logic             illegal;
   logic             is_mul;
   logic             start;
   logic             step;
   logic             finish;
   logic             last;
   logic             mplier_zero;
   logic [WIDTH-1:0] acc;

   // ---------------------------------------------------------------- decode
   always_comb begin
      ctrl    = ALU_ADD;
      illegal = 1'b0;
      {illegal, ctrl} = decode(bus.ALUOp, bus.Funct);
   end

   assign bus.ALUControl    = ctrl;
   assign bus.illegal_funct = illegal;
   assign is_mul            = (ctrl == ALU_MUL);

   // ------------------------------------------------------- datapath control
   assign start  = (state == ST_IDLE) && bus.valid && is_mul && !bus.flush;
   assign step   = (state == ST_RUN) && !bus.flush;
   assign finish = last || ((EARLY_EXIT != 0) && mplier_zero);

   mul_iter #(.WIDTH(WIDTH)) u_mul_iter (
      .clk         (clk),
      .clear       (reset),
      .start       (start),
      .step        (step),
      .a           (bus.a),
      .b           (bus.b),
      .acc         (acc),
      .last        (last),
      .mplier_zero (mplier_zero)
   );

   // -------------------------------------------------------------- sequencer
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         done_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) state <= ST_RUN;
            end
            ST_RUN: begin
               if (bus.flush) begin
                  state  <= ST_IDLE;
                  done_q <= 1'b0;
               end else if (finish) begin
                  state  <= ST_DONE;
                  done_q <= 1'b1;
               end
            end
            ST_DONE: begin
               // The retiring MUL is still on the bus here; it must not
               // start a second multiply.
               state  <= ST_IDLE;
               done_q <= 1'b0;
            end
            default: begin
               state  <= ST_IDLE;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   // --------------------------------------------------------------- outputs
   // Stall is combinational so the MUL is held from the very cycle it is
   // presented; reset forces it low so the pipeline is never frozen in reset.
   assign bus.stall = !reset &&
                      (((state == ST_IDLE) && bus.valid && is_mul) ||
                       (state == ST_RUN));

   // A flush landing on the DONE cycle discards the result handshake.
   assign bus.mul_done   = done_q && !bus.flush;
   assign bus.mul_result = acc;
   assign state_dbg      = state;

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_mdu
//   Directed bench for alu_ctrl_mdu at WIDTH=8: dut0 with EARLY_EXIT=0 and
//   dut1 with EARLY_EXIT=1. Products are pushed to exp_q when a MUL is
//   driven and popped when mul_done is seen.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_mdu;
   import alu_ctrl_pkg::*;

   localparam int W = 8;

   // ------------------------------------------------------ clock and reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         v0, v1, fl;
   logic [1:0]   aluop;
   logic [5:0]   funct;
   logic [W-1:0] a, b;
   state_t       st0, st1;

   alu_ctrl_mdu_if #(.WIDTH(W)) if0 ();
   alu_ctrl_mdu_if #(.WIDTH(W)) if1 ();

   assign if0.valid = v0;
   assign if0.flush = fl;
   assign if0.ALUOp = aluop;
   assign if0.Funct = funct;
   assign if0.a     = a;
   assign if0.b     = b;
   assign if1.valid = v1;
   assign if1.flush = fl;
   assign if1.ALUOp = aluop;
   assign if1.Funct = funct;
   assign if1.a     = a;
   assign if1.b     = b;

   alu_ctrl_mdu #(.WIDTH(W), .EARLY_EXIT(0)) dut0 (
      .clk(clk), .reset(rst), .bus(if0), .state_dbg(st0)
   );
   alu_ctrl_mdu #(.WIDTH(W), .EARLY_EXIT(1)) dut1 (
      .clk(clk), .reset(rst), .bus(if1), .state_dbg(st1)
   );

   // ------------------------------------------------------------ scoreboard
   logic [W-1:0] exp_q[$];
   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Reference decode table: {illegal, control}
   function automatic logic [3:0] model_dec(input logic [1:0] op,
                                            input logic [5:0] f);
      case (op)
         2'b00:   return {1'b0, 3'b010};
         2'b01:   return {1'b0, 3'b100};
         2'b11:   return {1'b0, 3'b010};
         default: begin
            case (f)
               6'b100000: return {1'b0, 3'b010};
               6'b100010: return {1'b0, 3'b100};
               6'b100100: return {1'b0, 3'b000};
               6'b100101: return {1'b0, 3'b001};
               6'b101010: return {1'b0, 3'b110};
               6'b011100: return {1'b0, 3'b101};
               default:   return {1'b1, 3'b010};
            endcase
         end
      endcase
   endfunction

   // Cycle (relative to the accept cycle 0) in which mul_done is expected.
   function automatic int model_done(input int sel, input logic [W-1:0] bv);
      int h;
      if (sel == 0) return W + 1;
      if (bv == '0) return 2;
      h = 0;
      for (int i = 0; i < W; i++) if (bv[i]) h = i;
      return h + 2;
   endfunction

   // --------------------------------------------------------- driver tasks
   // Called at a falling edge; presents a MUL on dut<sel>, holds it until
   // mul_done, then releases valid one cycle later.
   task automatic mul_op(input int sel, input logic [W-1:0] ta,
                         input logic [W-1:0] tbv);
      logic [2*W-1:0] full;
      logic [W-1:0]   exp_r;
      int             exp_d, done_cyc, stall_cnt;
      bit             seen;
      full  = {{W{1'b0}}, ta} * {{W{1'b0}}, tbv};
      exp_q.push_back(full[W-1:0]);
      exp_d = model_done(sel, tbv);
      a = ta; b = tbv; aluop = 2'b10; funct = 6'b011100; fl = 1'b0;
      if (sel == 0) v0 = 1'b1; else v1 = 1'b1;
      seen = 1'b0; done_cyc = -1; stall_cnt = 0;
      for (int c = 0; c <= 40; c++) begin
         #1;
         if ((sel == 0) ? if0.stall : if1.stall) stall_cnt++;
         if ((sel == 0) ? if0.mul_done : if1.mul_done) begin
            seen     = 1'b1;
            done_cyc = c;
            exp_r    = exp_q.pop_front();
            check("mul_result", (sel == 0) ? if0.mul_result : if1.mul_result, exp_r);
            break;
         end
         @(negedge clk);
      end
      check("mul_done_seen", seen, 1);
      if (!seen && exp_q.size() > 0) void'(exp_q.pop_front());
      check("mul_done_cycle", done_cyc, exp_d);
      check("stall_cycles", stall_cnt, exp_d);
      @(negedge clk);
      v0 = 1'b0; v1 = 1'b0;
      #1;
      check("mul_done_one_cycle", (sel == 0) ? if0.mul_done : if1.mul_done, 0);
      check("no_restart_in_done", (sel == 0) ? st0 : st1, ST_IDLE);
   endtask

   // ------------------------------------------------------------- sequence
   initial begin : main
      logic [3:0]   md;
      logic [W-1:0] pa, pb;
      logic [2*W-1:0] pfull;
      bit           extra_done;

      rst = 1'b1; v0 = 1'b0; v1 = 1'b0; fl = 1'b0;
      aluop = 2'b00; funct = 6'd0; a = '0; b = '0;
      repeat (2) @(negedge clk);

      // Reset state, with a MUL presented: stall must stay low in reset.
      v0 = 1'b1; aluop = 2'b10; funct = 6'b011100;
      #1;
      check("reset_stall", if0.stall, 0);
      check("reset_mul_done", if0.mul_done, 0);
      check("reset_mul_result", if0.mul_result, 0);
      check("reset_state", st0, ST_IDLE);
      @(negedge clk);
      rst = 1'b0; v0 = 1'b0;

      // Decode sweep across all ALUOp and Funct values.
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         aluop = i[7:6];
         funct = i[5:0];
         md    = model_dec(aluop, funct);
         v0    = (md[2:0] != 3'b101);
         #1;
         check("dec_ctrl", if0.ALUControl, md[2:0]);
         check("dec_illegal", if0.illegal_funct, md[3]);
         if (v0) check("nonmul_stall", if0.stall, 0);
      end
      @(negedge clk);
      v0 = 1'b0;
      aluop = 2'b10; funct = 6'b000000;
      #1;
      check("funct0_ctrl", if0.ALUControl, 3'b010);
      check("funct0_illegal", if0.illegal_funct, 1);
      @(negedge clk);

      // Basic MUL, wrap-around, back-to-back.
      mul_op(0, 8'd5, 8'd3);
      mul_op(0, 8'hFF, 8'hFF);
      mul_op(0, 8'd3, 8'd4);
      mul_op(0, 8'd6, 8'd7);

      // Flush in RUN cycle 4: no done, result frozen at 3 consumed bits.
      @(negedge clk);
      pa = 8'hB7; pb = 8'h5D;
      a = pa; b = pb; aluop = 2'b10; funct = 6'b011100; v0 = 1'b1;
      repeat (4) @(negedge clk);
      fl = 1'b1;
      @(negedge clk);
      fl = 1'b0; v0 = 1'b0;
      #1;
      pfull = {{W{1'b0}}, pa} * {{W{1'b0}}, 5'b0, pb[2:0]};
      check("flush_state", st0, ST_IDLE);
      check("flush_stall", if0.stall, 0);
      check("flush_mul_done", if0.mul_done, 0);
      check("flush_result_held", if0.mul_result, pfull[W-1:0]);
      extra_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         #1;
         if (if0.mul_done) extra_done = 1'b1;
      end
      check("flush_no_late_done", extra_done, 0);

      // Flush in IDLE blocks a start.
      @(negedge clk);
      v0 = 1'b1; fl = 1'b1;
      @(negedge clk);
      v0 = 1'b0; fl = 1'b0;
      #1;
      check("flush_idle_no_start", st0, ST_IDLE);

      // Reset (together with flush) mid-RUN.
      @(negedge clk);
      a = 8'd9; b = 8'd11; v0 = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1; fl = 1'b1;
      #1;
      check("reset_run_stall", if0.stall, 0);
      @(negedge clk);
      rst = 1'b0; fl = 1'b0; v0 = 1'b0;
      #1;
      check("reset_run_state", st0, ST_IDLE);
      check("reset_run_result", if0.mul_result, 0);
      check("reset_run_done", if0.mul_done, 0);
      check("reset_run_stall_after", if0.stall, 0);
      @(negedge clk);

      // Early exit.
      mul_op(1, 8'h53, 8'd2);
      mul_op(1, 8'h21, 8'd0);
      mul_op(1, 8'h11, 8'h80);

      // Random operands on both variants.
      for (int i = 0; i < 4; i++) begin
         mul_op(0, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
         mul_op(1, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
      end

      check("scoreboard_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
